// File: rtl/reg_file_mp_pkg.sv
// Shared constants and types for the multi-port integer register file.
package reg_file_mp_pkg;

    localparam int RF_XLEN     = 32;
    localparam int RF_NREGS    = 32;
    localparam int RF_AW       = $clog2(RF_NREGS);
    localparam int RF_NRD      = 2;
    localparam int RF_ZERO_REG = 0;

    // CLEAR zeroes the array one entry per cycle after reset; RUN is normal operation.
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_t;

endpackage

// File: rtl/reg_file_mp_if.sv
// Decode/writeback-facing bus of the register file.
//
// Handshake: there is no per-transaction valid/ready pair. ready qualifies the
// whole bus: while ready is 0, wr_en and alloc_en are ignored and every read
// port returns data 0 / busy 0. Once ready is 1 it stays 1 until reset, and
// wr_en / alloc_en take effect on every posedge they are sampled high.
interface reg_file_mp_if
    import reg_file_mp_pkg::*;
#(
    parameter int XLEN  = RF_XLEN,
    parameter int NREGS = RF_NREGS,
    parameter int NRD   = RF_NRD
);
    localparam int AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                alloc_en;
    logic [AW-1:0]       alloc_addr;
    logic                ready;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
        input  rd_data, rd_busy, ready
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
        output rd_data, rd_busy, ready
    );

endinterface

// File: rtl/reg_file_mp_reg_scoreboard.sv
// Per-register busy bits: set by decode allocation, cleared by writeback.
module reg_scoreboard
    import reg_file_mp_pkg::*;
#(
    parameter int NREGS = RF_NREGS,
    parameter int NRD   = RF_NRD,
    parameter int AW    = $clog2(NREGS)  // derived; leave at default
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              alloc_en,
    input  logic [AW-1:0]     alloc_addr,
    input  logic              rel_en,
    input  logic [AW-1:0]     rel_addr,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rd_busy
);

    logic [NREGS-1:0] busy;

    // Release applied before alloc so a same-cycle alloc (newer producer) wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else if (clear) begin
            busy <= '0;
        end else begin
            if (rel_en && rel_addr != AW'(RF_ZERO_REG)) begin
                busy[rel_addr] <= 1'b0;
            end
            if (alloc_en && alloc_addr != AW'(RF_ZERO_REG)) begin
                busy[alloc_addr] <= 1'b1;
            end
        end
    end

    // Raw busy lookup per read port; zero-register and bypass overrides live in the top.
    always_comb begin
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_busy[i] = busy[rd_addr[i*AW +: AW]];
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with write bypass, busy scoreboard and
// a post-reset clear sequencer that zeroes the array one entry per cycle.
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int XLEN   = RF_XLEN,
    parameter int NREGS  = RF_NREGS,
    parameter int NRD    = RF_NRD,
    parameter bit BYPASS = 1'b1,
    parameter int AW     = $clog2(NREGS)  // derived; leave at default
) (
    input  logic               clk,
    input  logic               rst,
    reg_file_mp_if.slave       bus,
    output rf_state_t          dbg_state
);

    rf_state_t       state;
    logic [AW-1:0]   clr_cnt;
    logic            ready_q;
    logic [XLEN-1:0] regs [NREGS];
    logic [AW-1:0]   rd_idx [NRD];
    logic [NRD-1:0]  sb_busy;
    logic            run;
    logic            wr_live;
    logic            alloc_live;

    assign run        = (state == RUN);
    assign wr_live    = run && bus.wr_en && (bus.wr_addr != AW'(RF_ZERO_REG));
    assign alloc_live = run && bus.alloc_en;
    assign bus.ready  = ready_q;
    assign dbg_state  = state;

    for (genvar g = 0; g < NRD; g++) begin : g_idx
        assign rd_idx[g] = bus.rd_addr[g*AW +: AW];
    end

    // Clear sequencer: entry 0 is hardwired, so the sweep starts at 1 and ends at NREGS-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= AW'(1);
            ready_q <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + AW'(1);
                    if (clr_cnt == AW'(NREGS - 1)) begin
                        state   <= RUN;
                        ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= CLEAR;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Array storage is deliberately not reset; the clear sequence zeroes it instead.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            regs[clr_cnt] <= '0;
        end else if (wr_live) begin
            regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    reg_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .AW    (AW)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .clear      (state == CLEAR),
        .alloc_en   (alloc_live),
        .alloc_addr (bus.alloc_addr),
        .rel_en     (wr_live),
        .rel_addr   (bus.wr_addr),
        .rd_addr    (bus.rd_addr),
        .rd_busy    (sb_busy)
    );

    // Read mux per port: zero register, then same-cycle bypass, then stored value.
    always_comb begin
        bus.rd_data = '0;
        bus.rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            if (run && rd_idx[i] != AW'(RF_ZERO_REG)) begin
                if (BYPASS && wr_live && bus.wr_addr == rd_idx[i]) begin
                    bus.rd_data[i*XLEN +: XLEN] = bus.wr_data;
                    bus.rd_busy[i]              = 1'b0;
                end else begin
                    bus.rd_data[i*XLEN +: XLEN] = regs[rd_idx[i]];
                    bus.rd_busy[i]              = sb_busy[i];
                end
            end
        end
    end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-read-port integer register file for the pipelined core.
- Adds same-cycle write-to-read bypass and a per-register busy scoreboard for hazard detection.
- Adds a post-reset clear sequencer that zeroes the array one entry per cycle, so reset needs no wide array reset.
- Sits between decode (read/alloc) and writeback (write/release).

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers; power of two, >= 4.
- NRD, 2, number of combinational read ports.
- AW, $clog2(NREGS), register index width; derived, not overridden.
- BYPASS, 1, 1 = a write in the current cycle is visible on reads in the same cycle; 0 = visible next cycle.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- rd_addr  in  NRD*AW  packed read indices; port i is bits [i*AW +: AW].
- rd_data  out  NRD*XLEN  packed read data.
- rd_busy  out  NRD  scoreboard busy bit of each read port's register.
- wr_en  in  1  writeback write enable.
- wr_addr  in  AW  writeback register index.
- wr_data  in  XLEN  writeback data.
- alloc_en  in  1  decode reserves a destination register (sets busy).
- alloc_addr  in  AW  register index to reserve.
- ready  out  1  high once the clear sequence has finished.

Behaviour:
- Reset is asynchronous and active-high, on port rst; single clock clk.
- Reset asserted:
  - state <= CLEAR, clear counter <= 1, all busy bits <= 0, ready <= 0.
  - Array contents are not reset directly.
- FSM CLEAR:
  - Each cycle writes 0 to regs[counter], then increments the counter.
  - At counter == NREGS-1, writes that entry and moves to RUN the next cycle. Clear takes NREGS-1 cycles after reset deasserts.
  - wr_en and alloc_en are ignored; busy bits stay 0.
  - rd_data returns 0 for all ports and rd_busy returns 0.
- FSM RUN: ready = 1. Stays in RUN until rst; no other exit.
- Register 0:
  - Reads always return 0 and rd_busy is always 0.
  - Writes and allocs to index 0 are discarded; busy[0] is never set.
- Write (RUN, wr_en, wr_addr != 0): regs[wr_addr] <= wr_data on posedge; busy[wr_addr] <= 0.
- Alloc (RUN, alloc_en, alloc_addr != 0): busy[alloc_addr] <= 1 on posedge.
- Simultaneous write and alloc to the same nonzero index: data is written and busy ends 1 (alloc is the newer producer and wins).
- Reads are combinational, with per-port priority:
  - addr == 0 -> 0.
  - Otherwise, if BYPASS and wr_en and wr_addr == addr -> wr_data, with rd_busy forced 0.
  - Otherwise regs[addr] and busy[addr].
- Bypass does not consider alloc; a same-cycle alloc is visible on rd_busy only from the next cycle.
- Multiple read ports may address the same register; each gets an independent result.
- rst asserted mid-CLEAR or mid-RUN: immediately returns to CLEAR with counter 1, and the full clear restarts.
- No read latency. Write-to-read latency is 0 cycles when BYPASS=1 and 1 cycle when BYPASS=0.

Decomposition:
- Shared core package:
  - XLEN, NREGS and reg-index width constants.
  - The RF state enum: CLEAR, RUN.
  - The zero-register index constant.
- Natural sub-module: reg_scoreboard, holding the NREGS busy bit vector.
  - Inputs: alloc, release (the write), the clear/reset condition.
  - Outputs: NRD lookups.
  - The top level keeps the array, the read mux/bypass and the clear FSM.

Test Plan:
- Reset release, default params:
  - ready is 0 for 31 cycles, then 1.
  - During CLEAR, wr_en=1 to reg 5 with 0xDEAD_BEEF is ignored; after ready, reading reg 5 gives 0.
- RUN, write reg 7 = 0x1234_5678 with rd_addr port0=7, BYPASS=1:
  - Same cycle, rd_data port0 = 0x1234_5678.
  - Repeat with BYPASS=0: old value (0) that cycle, new value next cycle.
- Write reg 0 = 0xFFFF_FFFF and alloc reg 0:
  - Port0 and port1 reading 0 return 0 with rd_busy = 0.
- Alloc reg 3, next cycle read 3:
  - rd_busy = 1.
  - Write reg 3 = 0xA5: next cycle rd_busy = 0 and data = 0xA5.
  - Same cycle as the write with BYPASS=1, rd_busy = 0 and data = 0xA5.
- Same-cycle alloc and write reg 9 = 0x55: next cycle rd_busy port0 = 1 and data = 0x55.
- Mid-RUN after populating regs 1..31, assert rst for 1 cycle:
  - All busy bits clear and ready drops.
  - After 31 cycles, every register reads 0.
